// File: rtl/sram_pkg.sv
// Shared widths and FSM state type for the asynchronous-SRAM host sequencer.
package sram_pkg;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;
  localparam int WAIT_CNT_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_e;

endpackage

// File: rtl/sram_host_seq.sv
// Host-side sequencer for an asynchronous SRAM: accepts one request at a time and
// walks SETUP / ACCESS / HOLD / DONE with every strobe driven straight from a flop.
module sram_host_seq
  import sram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter bit          HOLD_CYCLE  = 1'b1
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic                   iREQ,
  output logic                   oREADY,
  input  logic                   iRW,
  input  logic [SRAM_ADDR_W-1:0] iADDR,
  input  logic [SRAM_DATA_W-1:0] iWDATA,
  input  logic [1:0]             iBE_N,
  output logic                   oACK,
  output logic [SRAM_DATA_W-1:0] oRDATA,
  output logic [SRAM_ADDR_W-1:0] oSRAM_ADDR,
  output logic [SRAM_DATA_W-1:0] oSRAM_WDATA,
  input  logic [SRAM_DATA_W-1:0] iSRAM_RDATA,
  output logic                   oSRAM_WE_N,
  output logic                   oSRAM_OE_N,
  output logic                   oSRAM_CE_N,
  output logic [1:0]             oSRAM_BE_N
);

  state_e                 state_q;
  logic                   ready_q;
  logic                   ack_q;
  logic                   rw_q;
  logic [WAIT_CNT_W-1:0]  cnt_q;
  logic [SRAM_ADDR_W-1:0] addr_q;
  logic [SRAM_DATA_W-1:0] wdata_q;
  logic [SRAM_DATA_W-1:0] rdata_q;
  logic [1:0]             be_n_q;
  logic                   we_n_q;
  logic                   oe_n_q;
  logic                   ce_n_q;

  // Strobes are updated on the same edge as the state change, so each one already
  // reflects the state being entered and no output depends on an input combinationally.
  // NOTE: all state here uses non-blocking assignments so every flop samples the
  // pre-edge values; blocking assignments would make the result depend on statement order.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      ack_q   <= 1'b0;
      rw_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_n_q  <= 2'b11;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
    end else begin
      ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (iREQ && ready_q) begin
            rw_q    <= iRW;
            addr_q  <= iADDR;
            wdata_q <= iWDATA;
            // Reads always fetch the full word, so both lanes are enabled for them.
            be_n_q  <= iRW ? iBE_N : 2'b00;
            ready_q <= 1'b0;
            ce_n_q  <= 1'b0;
            we_n_q  <= 1'b1;
            oe_n_q  <= iRW;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          cnt_q   <= WAIT_CNT_W'(WAIT_CYCLES);
          we_n_q  <= ~rw_q;
          state_q <= ACCESS;
        end
        ACCESS: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - WAIT_CNT_W'(1);
          end else begin
            if (!rw_q) begin
              rdata_q <= iSRAM_RDATA;
            end
            we_n_q <= 1'b1;
            if (rw_q && HOLD_CYCLE) begin
              state_q <= HOLD;
            end else begin
              ce_n_q  <= 1'b1;
              oe_n_q  <= 1'b1;
              ack_q   <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        HOLD: begin
          ce_n_q  <= 1'b1;
          ack_q   <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          we_n_q  <= 1'b1;
          oe_n_q  <= 1'b1;
          ce_n_q  <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign oREADY      = ready_q;
  assign oACK        = ack_q;
  assign oRDATA      = rdata_q;
  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_WDATA = wdata_q;
  assign oSRAM_BE_N  = be_n_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_CE_N  = ce_n_q;

endmodule

// File: tb/tb_sram_host_seq.sv
// Bench for sram_host_seq: directed vector table, back-to-back and reset corner cases,
// a WAIT_CYCLES=0 / HOLD_CYCLE=0 build, and randomized traffic against a word-level model.
module tb_sram_host_seq;

  localparam int TB_WAIT = 1;
  localparam int TB_HOLD = 1;

  typedef struct {
    logic        rw;
    logic [17:0] addr;
    logic [15:0] wd;
    logic [1:0]  be_n;
    int          lat;
    int          we_cyc;
    int          oe_cyc;
    int          ce_cyc;
    logic [15:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  logic        req, rw, ready, ack;
  logic [17:0] addr, s_addr;
  logic [15:0] wdata, rdata, s_wdata, s_rdata;
  logic [1:0]  be_n, s_be_n;
  logic        we_n, oe_n, ce_n;

  logic        req0, rw0, ready0, ack0;
  logic [17:0] addr0, s_addr0;
  logic [15:0] wdata0, rdata0, s_wdata0, s_rdata0;
  logic [1:0]  be0, s_be0;
  logic        we0, oe0, ce0;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   ack_cnt = 0;
  int   ack0_cnt = 0;
  int   txn_cnt = 0;
  bit   mon_en = 1'b0;
  logic prev_ack = 1'b0;
  logic prev_ack0 = 1'b0;

  logic [15:0] mem [int];
  logic [15:0] ref_mem [int];
  logic [15:0] model_w;

  vec_t        vecs [10];
  vec_t        bb [3];
  vec_t        rv;
  bit          r_hold, r_pulse, prev_hold;
  logic [15:0] last_rd, mw;
  int          a_before, n_wait;

  always #5 clk = ~clk;

  sram_host_seq #(.WAIT_CYCLES(TB_WAIT), .HOLD_CYCLE(TB_HOLD)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req), .oREADY(ready), .iRW(rw), .iADDR(addr),
    .iWDATA(wdata), .iBE_N(be_n), .oACK(ack), .oRDATA(rdata), .oSRAM_ADDR(s_addr),
    .oSRAM_WDATA(s_wdata), .iSRAM_RDATA(s_rdata), .oSRAM_WE_N(we_n), .oSRAM_OE_N(oe_n),
    .oSRAM_CE_N(ce_n), .oSRAM_BE_N(s_be_n)
  );

  sram_host_seq #(.WAIT_CYCLES(0), .HOLD_CYCLE(1'b0)) dut0 (
    .iCLK(clk), .iRST_N(rst_n), .iREQ(req0), .oREADY(ready0), .iRW(rw0), .iADDR(addr0),
    .iWDATA(wdata0), .iBE_N(be0), .oACK(ack0), .oRDATA(rdata0), .oSRAM_ADDR(s_addr0),
    .oSRAM_WDATA(s_wdata0), .iSRAM_RDATA(s_rdata0), .oSRAM_WE_N(we0), .oSRAM_OE_N(oe0),
    .oSRAM_CE_N(ce0), .oSRAM_BE_N(s_be0)
  );

  // The second build sees a device that always answers 16'hBEEF.
  assign s_rdata0 = (!ce0 && !oe0) ? 16'hBEEF : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [17:0] a);
    if (mem.exists(int'(a))) return mem[int'(a)];
    return (a == 18'h3FFFF) ? 16'h1234 : 16'h0000;
  endfunction

  // Asynchronous SRAM model, evaluated away from the active edge.
  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      model_w = mem_rd(s_addr);
      if (!s_be_n[0]) model_w[7:0] = s_wdata[7:0];
      if (!s_be_n[1]) model_w[15:8] = s_wdata[15:8];
      mem[int'(s_addr)] = model_w;
    end
    s_rdata = (!ce_n && !oe_n) ? mem_rd(s_addr) : 16'hDEAD;
  end

  // Cycle-by-cycle strobe legality and ACK bookkeeping for both builds.
  always @(negedge clk) begin
    if (mon_en) begin
      check("we_oe_overlap", 32'(!we_n && !oe_n), 0);
      check("we_without_ce", 32'(!we_n && ce_n), 0);
      check("ready_while_busy", 32'(ready && !ce_n), 0);
      check("ack_two_cycles", 32'(ack && prev_ack), 0);
      check("w0_we_oe_overlap", 32'(!we0 && !oe0), 0);
      check("w0_ack_two_cycles", 32'(ack0 && prev_ack0), 0);
      if (ack === 1'b1) ack_cnt++;
      if (ack0 === 1'b1) ack0_cnt++;
    end
    prev_ack  = ack;
    prev_ack0 = ack0;
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_we_n"}, 32'(we_n), 1);
    check({tag, "_oe_n"}, 32'(oe_n), 1);
    check({tag, "_ce_n"}, 32'(ce_n), 1);
    check({tag, "_be_n"}, 32'(s_be_n), 32'h3);
    check({tag, "_ack"}, 32'(ack), 0);
    check({tag, "_addr"}, 32'(s_addr), 0);
    check({tag, "_wdata"}, 32'(s_wdata), 0);
    check({tag, "_rdata"}, 32'(rdata), 0);
  endtask

  task automatic do_txn(input vec_t v, input string tag, input bit hold, input bit b2b,
                        input bit pulse);
    int n, lat, we_c, oe_c, ce_c;
    bit stable;
    logic [1:0] be_seen;
    logic [15:0] rd_seen;
    @(negedge clk);
    req = 1'b1; rw = v.rw; addr = v.addr; wdata = v.wd; be_n = v.be_n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready), 1);
    if (b2b) check({tag, "_b2b_wait"}, n, 0);
    @(posedge clk);
    lat = 0; we_c = 0; oe_c = 0; ce_c = 0; stable = 1'b1; be_seen = 2'b11; rd_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, "_ready_busy"}, 32'(ready), 0);
        be_seen = s_be_n;
        rw = 1'($urandom); addr = 18'($urandom); wdata = 16'($urandom); be_n = 2'($urandom);
      end
      if (!hold) req = pulse && (k == 2);
      if (!we_n) we_c++;
      if (!oe_n) oe_c++;
      if (!ce_n) begin
        ce_c++;
        if (s_addr !== v.addr || (v.rw && s_wdata !== v.wd)) stable = 1'b0;
      end
      if (ack) begin
        lat = k;
        rd_seen = rdata;
        break;
      end
    end
    check({tag, "_latency"}, lat, v.lat);
    check({tag, "_we_cycles"}, we_c, v.we_cyc);
    check({tag, "_oe_cycles"}, oe_c, v.oe_cyc);
    check({tag, "_ce_cycles"}, ce_c, v.ce_cyc);
    check({tag, "_rdata"}, 32'(rd_seen), 32'(v.rd));
    check({tag, "_be_n"}, 32'(be_seen), 32'(v.rw ? v.be_n : 2'b00));
    check({tag, "_stable"}, 32'(stable), 1);
    txn_cnt++;
  endtask

  task automatic do0(input logic t_rw, input bit pulse, input string tag, input int exp_lat,
                     input int exp_we, input logic [15:0] exp_rd);
    int n, lat, we_c;
    @(negedge clk);
    req0 = 1'b1; rw0 = t_rw; addr0 = 18'h00042; wdata0 = 16'h7E57; be0 = 2'b00;
    n = 0;
    while (ready0 !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(ready0), 1);
    @(posedge clk);
    lat = 0; we_c = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      req0 = pulse && (k == 2);
      if (!we0) we_c++;
      if (ack0) begin
        lat = k;
        break;
      end
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_we_cycles"}, we_c, exp_we);
    check({tag, "_rdata"}, 32'(rdata0), 32'(exp_rd));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (n_bad=%0d)", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // rw, addr, wdata, be_n, latency, WE_N/OE_N/CE_N low cycles, oRDATA at ACK
    vecs[0] = '{1'b1, 18'h00155, 16'hA5C3, 2'b00, 5, 2, 0, 4, 16'h0000};
    vecs[1] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b00, 4, 0, 3, 3, 16'h1234};
    vecs[2] = '{1'b0, 18'h00155, 16'h0000, 2'b00, 4, 0, 3, 3, 16'hA5C3};
    vecs[3] = '{1'b1, 18'h00155, 16'hFFFF, 2'b11, 5, 2, 0, 4, 16'hA5C3};
    vecs[4] = '{1'b0, 18'h00155, 16'h0000, 2'b00, 4, 0, 3, 3, 16'hA5C3};
    vecs[5] = '{1'b1, 18'h00155, 16'h1111, 2'b10, 5, 2, 0, 4, 16'hA5C3};
    vecs[6] = '{1'b0, 18'h00155, 16'h0000, 2'b00, 4, 0, 3, 3, 16'hA511};
    vecs[7] = '{1'b1, 18'h00155, 16'h2222, 2'b01, 5, 2, 0, 4, 16'hA511};
    vecs[8] = '{1'b0, 18'h00155, 16'h0000, 2'b11, 4, 0, 3, 3, 16'h2211};
    vecs[9] = '{1'b0, 18'h3FFFF, 16'h0000, 2'b10, 4, 0, 3, 3, 16'h1234};
    bb[0]   = '{1'b1, 18'h00200, 16'hCAFE, 2'b00, 5, 2, 0, 4, 16'h1234};
    bb[1]   = '{1'b0, 18'h00200, 16'h0000, 2'b00, 4, 0, 3, 3, 16'hCAFE};
    bb[2]   = '{1'b1, 18'h00201, 16'h0F0F, 2'b00, 5, 2, 0, 4, 16'hCAFE};

    req = 1'b0; rw = 1'b0; addr = '0; wdata = '0; be_n = 2'b11;
    req0 = 1'b0; rw0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = 2'b11;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    check("por_w0_ce_n", 32'(ce0), 1);
    rst_n = 1'b1;
    @(negedge clk);
    check("por_ready", 32'(ready), 1);
    check("por_w0_ready", 32'(ready0), 1);
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i), 1'b0, 1'b0, 1'b0);

    // Three requests with iREQ held high throughout.
    repeat (2) @(negedge clk);
    a_before = ack_cnt;
    do_txn(bb[0], "b2b0", 1'b1, 1'b0, 1'b0);
    do_txn(bb[1], "b2b1", 1'b1, 1'b1, 1'b0);
    do_txn(bb[2], "b2b2", 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("b2b_ack_count", ack_cnt - a_before, 3);

    // Randomized traffic against a word-addressed memory model.
    last_rd = 16'hCAFE;
    prev_hold = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rv.rw   = 1'($urandom_range(0, 1));
      rv.addr = 18'h20000 | 18'($urandom_range(0, 15));
      rv.wd   = 16'($urandom);
      rv.be_n = 2'($urandom);
      r_hold  = (i != 59) && ($urandom_range(0, 3) == 0);
      r_pulse = !r_hold && ($urandom_range(0, 2) == 0);
      rv.lat    = 3 + TB_WAIT + ((rv.rw && TB_HOLD != 0) ? 1 : 0);
      rv.we_cyc = rv.rw ? TB_WAIT + 1 : 0;
      rv.oe_cyc = rv.rw ? 0 : TB_WAIT + 2;
      rv.ce_cyc = 2 + TB_WAIT + ((rv.rw && TB_HOLD != 0) ? 1 : 0);
      mw = ref_mem.exists(int'(rv.addr)) ? ref_mem[int'(rv.addr)] : 16'h0000;
      if (rv.rw) begin
        if (!rv.be_n[0]) mw[7:0] = rv.wd[7:0];
        if (!rv.be_n[1]) mw[15:8] = rv.wd[15:8];
        ref_mem[int'(rv.addr)] = mw;
        rv.rd = last_rd;
      end else begin
        rv.rd = mw;
        last_rd = mw;
      end
      if (!prev_hold) repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(rv, $sformatf("rnd%0d", i), r_hold, prev_hold, r_pulse);
      prev_hold = r_hold;
    end

    // Reset in the second ACCESS cycle of a write.
    repeat (2) @(negedge clk);
    a_before = ack_cnt;
    @(negedge clk);
    req = 1'b1; rw = 1'b1; addr = 18'h00300; wdata = 16'h5A5A; be_n = 2'b00;
    n_wait = 0;
    while (ready !== 1'b1 && n_wait < 50) begin
      @(negedge clk);
      n_wait++;
    end
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_we_low", 32'(we_n), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("rst_mid");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(ready), 1);
    repeat (8) @(negedge clk);
    check("rst_mid_no_ack", ack_cnt - a_before, 0);

    // WAIT_CYCLES=0, HOLD_CYCLE=0 build; the second access carries a busy-time iREQ pulse.
    do0(1'b0, 1'b0, "w0_rd", 3, 0, 16'hBEEF);
    repeat (2) @(negedge clk);
    a_before = ack0_cnt;
    do0(1'b1, 1'b1, "w0_wr_pulse", 3, 1, 16'hBEEF);
    repeat (6) @(negedge clk);
    check("w0_ack_count", ack0_cnt - a_before, 1);
    check("w0_ready_idle", 32'(ready0), 1);

    repeat (3) @(negedge clk);
    check("ack_total", ack_cnt, txn_cnt);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
